// File: rtl/seg_display_mux_if.sv
// Display-side bundle for seg_display_mux: CPU-facing inputs plus pin-facing outputs.
// Latency: none (wires only).
// No backpressure: plain level signals, no handshake.
interface seg_display_mux_if #(
  parameter int DIGITS   = 4,
  parameter int BRIGHT_W = 4
);
  logic [4*DIGITS-1:0] data;
  logic [DIGITS-1:0]   dp;
  logic                blank_lz;
  logic [BRIGHT_W-1:0] brightness;
  logic [DIGITS-1:0]   blink;
  logic [DIGITS-1:0]   anodes;
  logic [7:0]          seg;
  logic                frame_done;

  // Driver side: the CPU register block / testbench
  modport master (
    output data, dp, blank_lz, brightness, blink,
    input  anodes, seg, frame_done
  );

  // Display driver side
  modport slave (
    input  data, dp, blank_lz, brightness, blink,
    output anodes, seg, frame_done
  );
endinterface

// File: rtl/seg_display_mux.sv
// Multiplexed N-digit seven-segment scanner: frame-synchronous shadowing, PWM dimming, LZ blanking.
// Latency: anodes/seg/frame_done are registered, one cycle behind the scan counter state.
// No backpressure: free-running scan. Optional blink gating compiled in with `define DISP_BLINK_EN.
module seg_display_mux #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 1024,
  parameter int BRIGHT_W     = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic             clk,
  input  logic             rst,
  seg_display_mux_if.slave disp
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                first_q;
  logic [4*DIGITS-1:0] data_q, data_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  logic                blz_q, blz_d;
  logic [DIGITS-1:0]   anodes_q, anodes_d;
  logic [7:0]          seg_q, seg_d;
  logic                frame_done_q, frame_done_d;

  logic                slot_end, frame_end, latch;
  logic [4*DIGITS-1:0] cur_data;
  logic [DIGITS-1:0]   cur_dp;
  logic                cur_blz;
  logic [3:0]          nib;
  logic                dp_bit, lz_hit, zero_run, pwm_on, blink_off;
  logic [DIGITS-1:0]   lz_mask;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    logic [7:0] g;
    case (n)
      4'h0: g = 8'hFC;  4'h1: g = 8'h60;  4'h2: g = 8'hDA;  4'h3: g = 8'hF2;
      4'h4: g = 8'h66;  4'h5: g = 8'hB6;  4'h6: g = 8'hBE;  4'h7: g = 8'hE0;
      4'h8: g = 8'hFE;  4'h9: g = 8'hF6;  4'hA: g = 8'hEE;  4'hB: g = 8'h3E;
      4'hC: g = 8'h9C;  4'hD: g = 8'h7A;  4'hE: g = 8'h9E;  default: g = 8'h8E;
    endcase
    return g[7:1];
  endfunction

  // Scan counters: slot divider and digit index, plus shadow load points.
  always_comb begin
    slot_end  = (div_cnt_q == CNT_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);
    div_cnt_d = slot_end ? '0 : div_cnt_q + 1'b1;
    idx_d     = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    // First cycle out of reset loads too, so frame 0 already shows real data.
    latch     = first_q || frame_end;
    data_d    = latch ? disp.data : data_q;
    dp_d      = latch ? disp.dp : dp_q;
    blz_d     = latch ? disp.blank_lz : blz_q;
    // During the load cycle the shadow still holds stale/reset contents, so bypass it.
    cur_data  = first_q ? disp.data : data_q;
    cur_dp    = first_q ? disp.dp : dp_q;
    cur_blz   = first_q ? disp.blank_lz : blz_q;
  end

`ifdef DISP_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic              boff_q, boff_d;
  logic [DIGITS-1:0] blink_q, blink_d, cur_blink;

  // Blink phase: flips every BLINK_FRAMES frames, shadowed mask selects digits to gate.
  always_comb begin
    fcnt_d    = fcnt_q;
    boff_d    = boff_q;
    if (frame_end) begin
      if (fcnt_q == FC_W'(BLINK_FRAMES - 1)) begin
        fcnt_d = '0;
        boff_d = ~boff_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
    blink_d   = latch ? disp.blink : blink_q;
    cur_blink = first_q ? disp.blink : blink_q;
    blink_off = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (idx_q == IDX_W'(i)) blink_off = boff_q && cur_blink[i];
  end

  // Blink state registers; phase restarts in the lit half.
  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q  <= '0;
      boff_q  <= 1'b0;
      blink_q <= '0;
    end else begin
      fcnt_q  <= fcnt_d;
      boff_q  <= boff_d;
      blink_q <= blink_d;
    end
  end
`else
  assign blink_off = 1'b0;
  wire unused_blink = &{1'b0, disp.blink, BLINK_FRAMES[0]};
`endif

  // Digit decode: glyph, decimal point, leading-zero blanking and PWM anode gating.
  always_comb begin
    nib      = 4'h0;
    dp_bit   = 1'b0;
    lz_hit   = 1'b0;
    zero_run = 1'b1;
    lz_mask  = '0;
    // Walk down from the most significant digit while nibbles stay zero.
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run && (cur_data[4*i +: 4] == 4'h0);
      lz_mask[i] = cur_blz && zero_run;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib    = cur_data[4*i +: 4];
        dp_bit = cur_dp[i];
        lz_hit = lz_mask[i];
      end
    end
    pwm_on   = (&disp.brightness) || (div_cnt_q[BRIGHT_W-1:0] < disp.brightness);
    anodes_d = '0;
    for (int i = 0; i < DIGITS; i++)
      if (idx_q == IDX_W'(i)) anodes_d[i] = pwm_on && !blink_off;
    seg_d        = {(lz_hit ? 7'h00 : hex_glyph(nib)), dp_bit};
    frame_done_d = frame_end;
  end

  // State and output registers; reset aborts the scan and forces a fresh load.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q    <= '0;
      idx_q        <= '0;
      first_q      <= 1'b1;
      data_q       <= '0;
      dp_q         <= '0;
      blz_q        <= 1'b0;
      anodes_q     <= '0;
      seg_q        <= 8'h00;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      first_q      <= 1'b0;
      data_q       <= data_d;
      dp_q         <= dp_d;
      blz_q        <= blz_d;
      anodes_q     <= anodes_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign disp.anodes     = anodes_q;
  assign disp.seg        = seg_q;
  assign disp.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// Self-checking bench for seg_display_mux (DIGITS=4, REFRESH_DIV=16, BRIGHT_W=4).
// Reference model works from elapsed cycles since reset: slot, phase and frame by division.
// Build with DISP_BLINK_EN defined to exercise blinking with BLINK_FRAMES=2.
module tb_seg_display_mux;

  localparam int D  = 4;
  localparam int RD = 16;
  localparam int BW = 4;
  localparam int FR = RD * D;
`ifdef DISP_BLINK_EN
  localparam int BF       = 2;
  localparam bit BLINK_ON = 1'b1;
`else
  localparam int BF       = 64;
  localparam bit BLINK_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_display_mux_if #(.DIGITS(D), .BRIGHT_W(BW)) ifc ();

  seg_display_mux #(
    .DIGITS(D), .REFRESH_DIV(RD), .BRIGHT_W(BW), .BLINK_FRAMES(BF)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .disp (ifc.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: cycles since reset release and the shadow the display should use.
  int         s = 0;
  logic [15:0] sh_data;
  logic [3:0]  sh_dp, sh_blink;
  logic        sh_blz;
  logic [7:0]  glyph_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                  8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, s, got, exp);
    end
  endtask

  task automatic model_latch();
    sh_data  = ifc.data;
    sh_dp    = ifc.dp;
    sh_blz   = ifc.blank_lz;
    sh_blink = ifc.blink;
  endtask

  task automatic run_cycles(input int n);
    int slot, phase, frame;
    logic on, blanked;
    logic [3:0] nib, ea;
    logic [7:0] es;
    logic ef;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (s == 0) model_latch();
      slot    = (s / RD) % D;
      phase   = (s % RD) % (1 << BW);
      frame   = s / FR;
      nib     = 4'((sh_data >> (4 * slot)) & 16'hF);
      blanked = (slot > 0) && sh_blz && ((sh_data >> (4 * slot)) == 16'h0);
      on      = (ifc.brightness == 4'hF) || (phase < int'(ifc.brightness));
      if (BLINK_ON && ((frame / BF) % 2 == 1) && sh_blink[slot]) on = 1'b0;
      ea      = on ? 4'(1 << slot) : 4'h0;
      es      = blanked ? 8'h00 : glyph_tab[nib];
      es[0]   = sh_dp[slot];
      ef      = ((s + 1) % FR == 0);
      if (ef) model_latch();
      @(posedge clk);
      #1;
      check_eq("anodes", 32'(ifc.anodes), 32'(ea));
      check_eq("seg", 32'(ifc.seg), 32'(es));
      check_eq("frame_done", 32'(ifc.frame_done), 32'(ef));
      s++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_anodes", 32'(ifc.anodes), 32'h0);
    check_eq("rst_seg", 32'(ifc.seg), 32'h0);
    check_eq("rst_frame_done", 32'(ifc.frame_done), 32'h0);
    rst = 1'b0;
    s   = 0;
  endtask

  task automatic set_inputs(input logic [15:0] d, input logic [3:0] p, input logic lz,
                            input logic [3:0] b, input logic [3:0] bl);
    ifc.data       = d;
    ifc.dp         = p;
    ifc.blank_lz   = lz;
    ifc.brightness = b;
    ifc.blink      = bl;
  endtask

  initial begin
    logic [15:0] rd;
    logic [3:0]  nb;
    set_inputs(16'h1A8F, 4'b0000, 1'b0, 4'hF, 4'b0000);

    // Basic scan, glyphs and frame pulse
    do_reset();
    run_cycles(2 * FR);

    // Mid-frame data change must not show until the next frame
    run_cycles(20);
    ifc.data = 16'h0000;
    run_cycles(2 * FR - 20);

    // Leading-zero blanking with decimal point, then all-zero value
    set_inputs(16'h0050, 4'b0100, 1'b1, 4'hF, 4'b0000);
    run_cycles(2 * FR);
    ifc.data = 16'h0000;
    run_cycles(2 * FR);

    // PWM duty: partial, dark, full
    set_inputs(16'h9C3D, 4'b1001, 1'b0, 4'h4, 4'b0000);
    run_cycles(FR + 7);
    ifc.brightness = 4'h0;
    run_cycles(FR);
    ifc.brightness = 4'hF;
    run_cycles(FR);

    // Reset in the middle of digit 2, new data arrives with the reset
    run_cycles(((40 - (s % FR)) + FR) % FR + 1);
    ifc.data = 16'h2B7E;
    ifc.dp   = 4'b0010;
    do_reset();
    run_cycles(2 * FR);

    // Blink mask on digit 0 across eight frames
    set_inputs(16'h4321, 4'b0000, 1'b0, 4'hF, 4'b0001);
    do_reset();
    run_cycles(8 * FR);

    // Randomized inputs, lengths and occasional resets
    for (int it = 0; it < 25; it++) begin
      rd = 16'h0;
      for (int j = 0; j < 4; j++) begin
        nb = 4'($urandom);
        if ($urandom_range(0, 1) == 0) nb = 4'h0;
        rd[4*j +: 4] = nb;
      end
      set_inputs(rd, 4'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
      if ($urandom_range(0, 7) == 0) do_reset();
      run_cycles($urandom_range(1, 140));
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
